dmem_port: RTL and testbench

Data-memory responder for the pipelined RISC-V core: the memory-stage counterpart of the datapath's `ALUResult_M` / `WriteDataM` / `ReadData` interface. It decodes the memory-stage address, performs byte/half/word loads and stores against an internal word RAM, and exposes a small memory-mapped I/O window with a LED register, a cycle counter and a sticky misalignment status. Load data is combinational so the datapath's write-back pipeline register captures it at the end of M.

---
 rtl/dmem_port.sv | 164 ++++++++++++++++
 tb/tb_dmem_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// dmem_port: memory-stage data responder for the pipelined RISC-V core.
// It holds a word-organised RAM with byte-lane stores, and a small MMIO window
// containing LED, CYCLE, STATUS and ERRADDR. Load data is combinational, so the
// M/W pipeline register captures it at the end of the memory stage.
module dmem_port #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic [7:0]  Leds,
  output logic        ErrSticky
);

  localparam int          ABITS     = $clog2(4 * DEPTH_WORDS);
  localparam int          IBITS     = ABITS - 2;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  localparam logic [31:0] ADDR_LED     = 32'h8000_0000;
  localparam logic [31:0] ADDR_CYCLE   = 32'h8000_0004;
  localparam logic [31:0] ADDR_STATUS  = 32'h8000_0008;
  localparam logic [31:0] ADDR_ERRADDR = 32'h8000_000C;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_NONE} size_e;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [7:0]       r_leds;
  logic [31:0]      r_cycle;
  logic             r_err;
  logic [31:0]      r_erraddr;

  size_e            w_size;
  logic             w_signed;
  logic             w_misaligned;
  logic             w_load_en;
  logic             w_store_en;
  logic             w_mmio_sw;
  logic             w_in_ram;
  logic [IBITS-1:0] w_ram_idx;
  logic [31:0]      w_word_addr;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rword;
  logic [31:0]      w_shifted;

  // Decode access size and signedness from funct3; undefined codes select nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_size   = SZ_NONE;
    w_signed = 1'b0;
    case (Funct3_M)
      3'b000:  begin w_size = SZ_B; w_signed = 1'b1; end
      3'b001:  begin w_size = SZ_H; w_signed = 1'b1; end
      3'b010:  w_size = SZ_W;
      3'b100:  w_size = SZ_B;
      3'b101:  w_size = SZ_H;
      default: w_size = SZ_NONE;
    endcase
  end

  assign w_misaligned = (MemRead_M | MemWrite_M) &
                        (((w_size == SZ_H) & ALUResult_M[0]) |
                         ((w_size == SZ_W) & (ALUResult_M[1:0] != 2'b00)));

  // A store is ignored when a load is also requested, and is dropped under reset.
  assign w_load_en   = MemRead_M & ~w_misaligned & (w_size != SZ_NONE);
  assign w_store_en  = MemWrite_M & ~MemRead_M & ~w_misaligned &
                       (w_size != SZ_NONE) & ~reset;
  assign w_mmio_sw   = w_store_en & (w_size == SZ_W);

  assign w_in_ram    = (ALUResult_M < RAM_BYTES);
  assign w_ram_idx   = ALUResult_M[ABITS-1:2];
  assign w_word_addr = {ALUResult_M[31:2], 2'b00};

  // Build byte enables and lane-replicated store data for the addressed size.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteDataM;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << ALUResult_M[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        w_be    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      SZ_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM byte-lane write on the edge that ends M.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately left out of reset so it maps onto plain memory.
    if (w_store_en && w_in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_ram_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // MMIO registers: LED, free-running CYCLE, sticky misalignment flag and its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds    <= '0;
      r_cycle   <= '0;
      r_err     <= 1'b0;
      r_erraddr <= '0;
    end else begin
      // NOTE: with non-blocking assignments the last one in program order wins,
      // which gives a CYCLE store priority over the increment.
      r_cycle <= r_cycle + 32'd1;
      if (w_mmio_sw && (w_word_addr == ADDR_LED))   r_leds  <= WriteDataM[7:0];
      if (w_mmio_sw && (w_word_addr == ADDR_CYCLE)) r_cycle <= WriteDataM;
      if (w_misaligned) begin
        r_err <= 1'b1;
        if (!r_err) r_erraddr <= ALUResult_M;
      end else if (w_mmio_sw && (w_word_addr == ADDR_STATUS) && WriteDataM[0]) begin
        r_err <= 1'b0;
      end
    end
  end

  // Select the addressed word from RAM or the MMIO window; unmapped reads give 0.
  always_comb begin
    w_rword = '0;
    if (w_in_ram) begin
      w_rword = r_mem[w_ram_idx];
    end else begin
      case (w_word_addr)
        ADDR_LED:     w_rword = {24'd0, r_leds};
        ADDR_CYCLE:   w_rword = r_cycle;
        ADDR_STATUS:  w_rword = {31'd0, r_err};
        ADDR_ERRADDR: w_rword = r_erraddr;
        default:      w_rword = '0;
      endcase
    end
  end

  assign w_shifted = w_rword >> {ALUResult_M[1:0], 3'b000};

  // Extract and extend the addressed byte/half; suppressed loads return 0.
  always_comb begin
    ReadData = '0;
    if (w_load_en) begin
      case (w_size)
        SZ_B:    ReadData = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
        SZ_H:    ReadData = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
        SZ_W:    ReadData = w_rword;
        default: ReadData = '0;
      endcase
    end
  end

  assign Leds      = r_leds;
  assign ErrSticky = r_err;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed scenarios followed by random
// traffic, all compared against a byte-addressed behavioural model.
module tb_dmem_port;

  localparam int          DEPTH     = 64;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [31:0] A_LED     = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0004;
  localparam logic [31:0] A_STATUS  = 32'h8000_0008;
  localparam logic [31:0] A_ERRADDR = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite_M;
  logic        MemRead_M;
  logic [2:0]  Funct3_M;
  logic [31:0] ALUResult_M;
  logic [31:0] WriteDataM;
  logic [31:0] ReadData;
  logic [7:0]  Leds;
  logic        ErrSticky;

  dmem_port #(.DEPTH_WORDS(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite_M  (MemWrite_M),
    .MemRead_M   (MemRead_M),
    .Funct3_M    (Funct3_M),
    .ALUResult_M (ALUResult_M),
    .WriteDataM  (WriteDataM),
    .ReadData    (ReadData),
    .Leds        (Leds),
    .ErrSticky   (ErrSticky)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat byte array plus the architectural registers.
  logic [7:0]  m_mem [4*DEPTH];
  logic [7:0]  m_leds;
  logic [31:0] m_cycle;
  logic        m_err;
  logic [31:0] m_erraddr;
  bit          m_valid = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] base);
    if (base < RAM_BYTES)
      return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    if (base == A_LED)     return {24'd0, m_leds};
    if (base == A_CYCLE)   return m_cycle;
    if (base == A_STATUS)  return {31'd0, m_err};
    if (base == A_ERRADDR) return m_erraddr;
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    logic [31:0] v;
    sz = acc_size(f3);
    if (sz == 0) return 32'd0;
    if ((a % sz) != 0) return 32'd0;
    v = model_word(a & ~32'd3) >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Apply the effect of one clock edge to the model.
  task automatic model_step(input logic rst, input logic we, input logic re,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int unsigned sz;
    bit          mis;
    logic [31:0] next_cycle;
    if (rst) begin
      m_valid = 1'b1; m_leds = 0; m_cycle = 0; m_err = 0; m_erraddr = 0;
      return;
    end
    sz  = acc_size(f3);
    mis = (we || re) && (sz != 0) && ((a % sz) != 0);
    next_cycle = m_cycle + 1;
    if (mis) begin
      if (!m_err) m_erraddr = a;
      m_err = 1'b1;
    end else if (we && !re && sz != 0) begin
      if (a < RAM_BYTES) begin
        for (int k = 0; k < 4; k++)
          if (k < sz) m_mem[a + k] = wd[8*k +: 8];
      end else if (sz == 4) begin
        if (a == A_LED)                  m_leds = wd[7:0];
        if (a == A_CYCLE)                next_cycle = wd;
        if (a == A_STATUS && wd[0])      m_err = 1'b0;
      end
    end
    m_cycle = next_cycle;
  endtask

  // One bus cycle: drive at the falling edge, sample 1ns later, commit at the rising edge.
  task automatic access(input string tag, input logic rst, input logic we, input logic re,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset = rst; MemWrite_M = we; MemRead_M = re;
    Funct3_M = f3; ALUResult_M = a; WriteDataM = wd;
    #1;
    rd_obs = ReadData;
    if (m_valid) begin
      if (re) check({tag, "_rd"}, ReadData, model_load(f3, a));
      check({tag, "_leds"}, {24'd0, Leds}, {24'd0, m_leds});
      check({tag, "_err"}, {31'd0, ErrSticky}, {31'd0, m_err});
    end
    @(posedge clk);
    model_step(rst, we, re, f3, a, wd);
  endtask

  task automatic idle();
    access("idle", 1'b0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
  endtask

  logic [31:0] ra, rw;
  logic [2:0]  rf;
  int unsigned kind, op;
  logic        rr;

  initial begin
    reset = 1'b1; MemWrite_M = 0; MemRead_M = 0; Funct3_M = 0; ALUResult_M = 0; WriteDataM = 0;

    access("rst0", 1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    access("rst1", 1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    check("rst_leds", {24'd0, Leds}, 32'd0);
    check("rst_err", {31'd0, ErrSticky}, 32'd0);

    // Reads of CYCLE right after reset: 0 then 1.
    access("cyc_a", 1'b0, 1'b0, 1'b1, 3'b010, A_CYCLE, 32'd0);
    check("cyc_after_rst0", rd_obs, 32'd0);
    access("cyc_b", 1'b0, 1'b0, 1'b1, 3'b010, A_CYCLE, 32'd0);
    check("cyc_after_rst1", rd_obs, 32'd1);

    // Fill RAM with known data so the model fully describes it.
    for (int i = 0; i < DEPTH; i++)
      access("init", 1'b0, 1'b1, 1'b0, 3'b010, 32'(4 * i), $urandom);

    access("sw_dead", 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
    access("lw_dead", 1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'd0);
    check("tp_lw_dead", rd_obs, 32'hDEADBEEF);

    access("sw_20", 1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h80F0_7F01);
    access("lb20", 1'b0, 1'b0, 1'b1, 3'b000, 32'h20, 32'd0); check("tp_lb20", rd_obs, 32'h0000_0001);
    access("lb21", 1'b0, 1'b0, 1'b1, 3'b000, 32'h21, 32'd0); check("tp_lb21", rd_obs, 32'h0000_007F);
    access("lb22", 1'b0, 1'b0, 1'b1, 3'b000, 32'h22, 32'd0); check("tp_lb22", rd_obs, 32'hFFFF_FFF0);
    access("lbu23", 1'b0, 1'b0, 1'b1, 3'b100, 32'h23, 32'd0); check("tp_lbu23", rd_obs, 32'h0000_0080);
    access("lh22", 1'b0, 1'b0, 1'b1, 3'b001, 32'h22, 32'd0); check("tp_lh22", rd_obs, 32'hFFFF_80F0);
    access("lhu22", 1'b0, 1'b0, 1'b1, 3'b101, 32'h22, 32'd0); check("tp_lhu22", rd_obs, 32'h0000_80F0);

    access("sw30", 1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
    access("sb31", 1'b0, 1'b1, 1'b0, 3'b000, 32'h31, 32'hFFFF_FFAA);
    access("lw30a", 1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'd0); check("tp_sb31", rd_obs, 32'h0000_AA00);
    access("sh32", 1'b0, 1'b1, 1'b0, 3'b001, 32'h32, 32'hFFFF_1234);
    access("lw30b", 1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'd0); check("tp_sh32", rd_obs, 32'h1234_AA00);

    // Misalignment: suppressed load, sticky flag, first-address capture, W1C.
    access("lw42", 1'b0, 1'b0, 1'b1, 3'b010, 32'h42, 32'd0);
    check("tp_lw42_rd", rd_obs, 32'd0);
    #1 check("tp_err_set", {31'd0, ErrSticky}, 32'd1);
    access("ea1", 1'b0, 1'b0, 1'b1, 3'b010, A_ERRADDR, 32'd0); check("tp_erraddr", rd_obs, 32'h42);
    access("sh45", 1'b0, 1'b1, 1'b0, 3'b001, 32'h45, 32'h5555);
    access("ea2", 1'b0, 1'b0, 1'b1, 3'b010, A_ERRADDR, 32'd0); check("tp_erraddr_keep", rd_obs, 32'h42);
    access("lw40", 1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'd0);
    access("lw44", 1'b0, 1'b0, 1'b1, 3'b010, 32'h44, 32'd0);
    access("w1c", 1'b0, 1'b1, 1'b0, 3'b010, A_STATUS, 32'd1);
    #1 check("tp_err_clr", {31'd0, ErrSticky}, 32'd0);

    // CYCLE load and wrap.
    access("cyc_w", 1'b0, 1'b1, 1'b0, 3'b010, A_CYCLE, 32'hFFFF_FFFE);
    access("cyc_r0", 1'b0, 1'b0, 1'b1, 3'b010, A_CYCLE, 32'd0); check("tp_cyc0", rd_obs, 32'hFFFF_FFFE);
    access("cyc_r1", 1'b0, 1'b0, 1'b1, 3'b010, A_CYCLE, 32'd0); check("tp_cyc1", rd_obs, 32'hFFFF_FFFF);
    access("cyc_r2", 1'b0, 1'b0, 1'b1, 3'b010, A_CYCLE, 32'd0); check("tp_cyc2", rd_obs, 32'h0);

    // LED write, reset dropping a concurrent store, and an unmapped address.
    access("led_w", 1'b0, 1'b1, 1'b0, 3'b010, A_LED, 32'h5A);
    #1 check("tp_leds", {24'd0, Leds}, 32'h5A);
    access("rst_led", 1'b1, 1'b1, 1'b0, 3'b010, A_LED, 32'h33);
    #1 check("tp_rst_leds", {24'd0, Leds}, 32'd0);
    access("cyc_rst", 1'b0, 1'b0, 1'b1, 3'b010, A_CYCLE, 32'd0); check("tp_rst_cyc", rd_obs, 32'd0);
    access("um_w", 1'b0, 1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'h1234_5678);
    access("um_r", 1'b0, 1'b0, 1'b1, 3'b010, 32'h4000_0000, 32'd0); check("tp_unmapped", rd_obs, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)      ra = 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (kind < 9) ra = A_LED + 32'($urandom_range(0, 15));
      else               ra = $urandom;
      rf = 3'($urandom_range(0, 7));
      rw = $urandom;
      rr = ($urandom_range(0, 59) == 0);
      op = $urandom_range(0, 9);
      if (op < 4)       access("rnd", rr, 1'b0, 1'b1, rf, ra, rw);
      else if (op < 8)  access("rnd", rr, 1'b1, 1'b0, rf, ra, rw);
      else if (op < 9)  access("rnd", rr, 1'b1, 1'b1, rf, ra, rw);
      else              access("rnd", rr, 1'b0, 1'b0, rf, ra, rw);
    end

    // Sweep back over all RAM words to catch any stray write.
    for (int i = 0; i < DEPTH; i++)
      access("sweep", 1'b0, 1'b0, 1'b1, 3'b010, 32'(4 * i), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
